// File: rtl/param_sync_rx_if.sv
// param_sync_rx_if
//   Bundles the SPI-domain command-decoder signals that cross into the
//   sys_clk domain, together with the feedback word returned to the SPI side.
//   master: SPI command block (drives the acks and words, reads the feedback)
//   slave : param_sync_rx (reads the acks and words, drives the feedback)
//   Signals:
//     machine_start_ack, machine_stop_ack  stretched run-control pulses
//     *_data_async                         parameter words, stable while ack high
//     change_*_ack                         stretched per-parameter update pulses
//     feedback_data_async                  32-bit status word
//     change_feedback_ack                  feedback-valid level
interface param_sync_rx_if;
  logic        machine_start_ack;
  logic        machine_stop_ack;
  logic [15:0] Ton_data_async;
  logic [15:0] Toff_data_async;
  logic [15:0] Ip_data_async;
  logic [15:0] waveform_data_async;
  logic        change_Ton_ack;
  logic        change_Toff_ack;
  logic        change_Ip_ack;
  logic        change_waveform_ack;
  logic [31:0] feedback_data_async;
  logic        change_feedback_ack;

  modport master (
    output machine_start_ack, machine_stop_ack,
    output Ton_data_async, Toff_data_async, Ip_data_async, waveform_data_async,
    output change_Ton_ack, change_Toff_ack, change_Ip_ack, change_waveform_ack,
    input  feedback_data_async, change_feedback_ack
  );

  modport slave (
    input  machine_start_ack, machine_stop_ack,
    input  Ton_data_async, Toff_data_async, Ip_data_async, waveform_data_async,
    input  change_Ton_ack, change_Toff_ack, change_Ip_ack, change_waveform_ack,
    output feedback_data_async, change_feedback_ack
  );
endinterface

// File: rtl/param_sync_rx.sv
// param_sync_rx
//   Brings the SPI command-decoder outputs into the sys_clk domain, validates
//   each parameter update, holds the machine run state, applies parameters
//   immediately while stopped or at a discharge-cycle boundary while running,
//   and publishes a periodic 32-bit feedback word with a level ack.
//   Ports:
//     sys_clk, rst_n        clock; synchronous active-low reset
//     bus                   SPI-side acks/words in, feedback word/ack out
//     cycle_boundary        one-cycle pulse at the end of each Toff
//     measured_current      latest current sample (goes into the feedback word)
//     Ton/Toff/Ip/waveform_data  active parameters
//     machine_on            run state
//     param_commit          one-cycle pulse on any active-parameter change
//     err_flags             sticky rejects {waveform, Ip, Toff, Ton}
module param_sync_rx #(
  parameter int TON_MIN             = 1,
  parameter int TON_MAX             = 1000,
  parameter int TOFF_MIN            = 5,
  parameter int IP_MAX              = 100,
  parameter int WAVEFORM_NUM        = 4,
  parameter int FEEDBACK_PERIOD     = 1000,
  parameter int FEEDBACK_ACK_CYCLES = 8
) (
  input  logic           sys_clk,
  input  logic           rst_n,
  param_sync_rx_if.slave bus,
  input  logic           cycle_boundary,
  input  logic [15:0]    measured_current,
  output logic [15:0]    Ton_data,
  output logic [15:0]    Toff_data,
  output logic [15:0]    Ip_data,
  output logic [15:0]    waveform_data,
  output logic           machine_on,
  output logic           param_commit,
  output logic [3:0]     err_flags
);

  localparam int FC_W = $clog2(FEEDBACK_PERIOD);
  localparam logic [FC_W-1:0] FC_LAST      = FC_W'(FEEDBACK_PERIOD - 1);
  localparam logic [FC_W-1:0] FC_LOAD      = FC_W'(1);
  localparam logic [FC_W-1:0] FC_ACK_FIRST = FC_W'(2);
  localparam logic [FC_W-1:0] FC_ACK_LAST  = FC_W'(FEEDBACK_ACK_CYCLES + 1);
  localparam logic [15:0] RST_VAL [4] = '{16'd80, 16'd20, 16'd30, 16'd0};

  typedef enum logic {OFF = 1'b0, RUN = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_sync [6];
  logic [5:0]  w_ack, w_edge, r_evt;
  logic        w_start, w_stop;
  logic [3:0]  w_pevt, w_ok, w_acc, w_rej, w_direct_wr, w_shadow_wr;
  logic [15:0] w_raw [4];
  logic [15:0] r_active [4];
  logic [15:0] r_shadow [4];
  logic [3:0]  r_pending;
  logic [3:0]  r_err;
  logic        r_param_commit;
  logic        w_commit_all;
  logic [FC_W-1:0] r_fc;
  logic [31:0] r_fb_data;
  logic        r_fb_ack;

  // Index order: start, stop, Ton, Toff, Ip, waveform
  assign w_ack = {bus.change_waveform_ack, bus.change_Ip_ack, bus.change_Toff_ack,
                  bus.change_Ton_ack, bus.machine_stop_ack, bus.machine_start_ack};

  always_comb begin
    w_edge = '0;
    for (int unsigned i = 0; i < 6; i++) w_edge[i] = r_sync[i][1] & ~r_sync[i][2];
  end

  // Rising-edge detect is registered once more so every event lands on a
  // clean flop output; all actions then occur three edges after first sample.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 6; i++) r_sync[i] <= '0;
      r_evt <= '0;
    end else begin
      for (int unsigned i = 0; i < 6; i++) r_sync[i] <= {r_sync[i][1:0], w_ack[i]};
      r_evt <= w_edge;
    end
  end

  assign w_start = r_evt[0];
  assign w_stop  = r_evt[1];
  assign w_pevt  = r_evt[5:2];

  assign w_raw[0] = bus.Ton_data_async;
  assign w_raw[1] = bus.Toff_data_async;
  assign w_raw[2] = bus.Ip_data_async;
  assign w_raw[3] = bus.waveform_data_async;

  assign w_ok[0] = (w_raw[0] >= 16'(TON_MIN)) && (w_raw[0] <= 16'(TON_MAX));
  assign w_ok[1] = (w_raw[1] >= 16'(TOFF_MIN));
  assign w_ok[2] = (w_raw[2] <= 16'(IP_MAX));
  assign w_ok[3] = (w_raw[3] <  16'(WAVEFORM_NUM));

  assign w_acc = w_pevt & w_ok;
  assign w_rej = w_pevt & ~w_ok;

  // Run FSM: stop has priority over start
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == OFF) begin
      if (w_start && !w_stop) w_state_nxt = RUN;
    end else begin
      if (w_stop) w_state_nxt = OFF;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) r_state <= OFF;
    else        r_state <= w_state_nxt;
  end

  // Pending shadows commit at a boundary or on the RUN->OFF transition. A
  // data event on the stopping cycle bypasses the shadow so it is not left
  // stranded as pending while OFF.
  assign w_commit_all = (r_state == RUN) && (cycle_boundary || w_stop) && (|r_pending);
  assign w_direct_wr  = w_acc & {4{(r_state == OFF) || w_stop}};
  assign w_shadow_wr  = w_acc & ~w_direct_wr;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_active[i] <= RST_VAL[i];
        r_shadow[i] <= RST_VAL[i];
      end
      r_pending      <= '0;
      r_err          <= '0;
      r_param_commit <= 1'b0;
    end else begin
      r_param_commit <= w_commit_all | (|w_direct_wr);
      r_err          <= (w_start ? 4'b0000 : r_err) | w_rej;
      r_pending      <= (w_commit_all ? 4'b0000 : r_pending) | w_shadow_wr;
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_commit_all && r_pending[i]) r_active[i] <= r_shadow[i];
        if (w_direct_wr[i])               r_active[i] <= w_raw[i];
        if (w_shadow_wr[i])               r_shadow[i] <= w_raw[i];
      end
    end
  end

  // Feedback: load at fc=1, ack visible for FEEDBACK_ACK_CYCLES cycles
  // starting one cycle later, so data always leads the ack by a cycle.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_fc      <= '0;
      r_fb_data <= '0;
      r_fb_ack  <= 1'b0;
    end else begin
      r_fc <= (r_fc == FC_LAST) ? '0 : r_fc + 1'b1;
      if (r_fc == FC_LOAD)
        r_fb_data <= {10'b0, |r_pending, machine_on, r_err, measured_current};
      r_fb_ack <= (r_fc >= FC_ACK_FIRST) && (r_fc <= FC_ACK_LAST);
    end
  end

  assign Ton_data                = r_active[0];
  assign Toff_data               = r_active[1];
  assign Ip_data                 = r_active[2];
  assign waveform_data           = r_active[3];
  assign machine_on              = (r_state == RUN);
  assign param_commit            = r_param_commit;
  assign err_flags               = r_err;
  assign bus.feedback_data_async = r_fb_data;
  assign bus.change_feedback_ack = r_fb_ack;

endmodule
